// File: rtl/word_tx_serializer_pkg.sv
// word_tx_serializer_pkg: serializer FSM states, word geometry and byte selection helper.
package word_tx_serializer_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_IDLE, STROBE, WAIT_BUSY, NEXT} tx_ser_state_t;
    localparam int BYTES_PER_WORD = 4;
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx, input logic msb_first);
        logic [1:0] k;
        k = msb_first ? 2'd3 - idx : idx;
        return w[{k, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/word_tx_serializer_sync_word_fifo.sv
// sync_word_fifo: single-clock word FIFO with occupancy count and synchronous clear.
module sync_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/word_tx_serializer.sv
// word_tx_serializer: queues 32-bit words and feeds them bytewise to the RS232 TX handshake.
module word_tx_serializer
    import word_tx_serializer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    input  logic                   flush,
    output logic [7:0]             TX,
    output logic                   start_TX,
    input  logic                   TX_ready,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    tx_ser_state_t state;
    logic [31:0] word_q, head;
    logic [1:0] idx;
    logic discard, full, empty, pop, push;
    assign pop = state == LOAD;
    assign word_ready = !full || pop;
    assign push = word_valid && word_ready && !flush;
    assign busy = !empty || state != IDLE;

    sync_word_fifo #(.WIDTH(32), .DEPTH(DEPTH)) fifo (
        .clk(clk), .rst(rst), .clear(flush), .push(push), .pop(pop),
        .din(word_in), .dout(head), .full(full), .empty(empty), .level(level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            word_q <= '0;
            idx <= '0;
            discard <= 1'b0;
            TX <= '0;
            start_TX <= 1'b0;
            overflow <= 1'b0;
        end else begin
            start_TX <= 1'b0;
            overflow <= !flush && (overflow || (word_valid && !word_ready));
            case (state)
                IDLE: if (!empty && !flush) state <= LOAD;
                LOAD: begin
                    word_q <= head;
                    idx <= '0;
                    state <= flush ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (flush) state <= IDLE;
                    else if (TX_ready) begin
                        TX <= pick_byte(word_q, idx, MSB_FIRST);
                        start_TX <= 1'b1;
                        state <= STROBE;
                    end
                end
                STROBE: state <= flush ? IDLE : WAIT_BUSY;
                WAIT_BUSY: begin
                    // a flush here lets the accepted byte finish, then drops the rest
                    discard <= TX_ready && (discard || flush);
                    if (!TX_ready) state <= (discard || flush) ? IDLE : NEXT;
                end
                NEXT: begin
                    if (flush) state <= IDLE;
                    else if (idx == 2'(BYTES_PER_WORD - 1)) state <= empty ? IDLE : LOAD;
                    else begin
                        idx <= idx + 2'd1;
                        state <= WAIT_IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
